alu_acc_ctrl: RTL and testbench

//   Registered accumulator stage directly downstream of the N-bit ALU on the DE10-Lite.
//   - On each debounced press of a push-button it captures either ALU o_result/o_carry_out or a switch operand.
//   - o_acc feeds back into ALU i_a, which turns the combinational ALU into a step-by-step calculator.
//   - Also outputs a commit strobe and a press counter for HEX/LED display.

---
 rtl/alu_acc_ctrl_pkg.sv | 8 +
 rtl/alu_acc_ctrl_key_debouncer.sv | 70 +++++++
 rtl/alu_acc_ctrl.sv | 54 +++++
 tb/tb_alu_acc_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_acc_ctrl_pkg.sv
// Shared types and constants for the accumulator stage and its key debouncer.
package alu_acc_pkg;

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} deb_state_t;

    localparam int unsigned COUNT_W = 8;

endpackage

// File: rtl/alu_acc_ctrl_key_debouncer.sv
// Push-button conditioner: 2-flop synchroniser plus press/release debounce FSM.
// Emits a single-cycle o_press for each accepted press.
module key_debouncer
    import alu_acc_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key_n,
    output logic o_press
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync;
    logic             key_s;
    deb_state_t       state, next_state;
    logic [CNT_W-1:0] cnt, next_cnt;

    // Synchroniser resets to the released level so reset never looks like a press.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) sync <= 2'b11;
        else       sync <= {sync[0], i_key_n};
    end

    assign key_s = sync[1];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // next_cnt defaults to zero so any state change clears the counter.
    always_comb begin
        next_state = state;
        next_cnt   = '0;
        case (state)
            IDLE: begin
                if (!key_s) next_state = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (key_s)                 next_state = IDLE;
                else if (cnt == CNT_LAST)  next_state = HELD;
                else                       next_cnt   = cnt + CNT_W'(1);
            end
            HELD: begin
                if (key_s) next_state = RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
                if (!key_s)                next_state = HELD;
                else if (cnt == CNT_LAST)  next_state = IDLE;
                else                       next_cnt   = cnt + CNT_W'(1);
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        o_press = 1'b0;
        if (state == PRESS_WAIT && !key_s && cnt == CNT_LAST) o_press = 1'b1;
    end

endmodule

// File: rtl/alu_acc_ctrl.sv
// Accumulator stage behind the ALU: each debounced key press commits either the
// switch operand or the ALU result/carry, and counts commits.
module alu_acc_ctrl
    import alu_acc_pkg::*;
#(
    parameter int unsigned N               = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_key_n,
    input  logic               i_load,
    input  logic [N-1:0]       i_operand,
    input  logic [N-1:0]       i_result,
    input  logic               i_carry_out,
    output logic [N-1:0]       o_acc,
    output logic               o_carry,
    output logic               o_strobe,
    output logic [COUNT_W-1:0] o_count
);

    logic press;

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_key_n (i_key_n),
        .o_press (press)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_acc    <= '0;
            o_carry  <= 1'b0;
            o_strobe <= 1'b0;
            o_count  <= '0;
        end else begin
            o_strobe <= press;
            if (press) begin
                if (i_load) begin
                    o_acc   <= i_operand;
                    o_carry <= 1'b0;
                end else begin
                    o_acc   <= i_result;
                    o_carry <= i_carry_out;
                end
                o_count <= o_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_acc_ctrl.sv
// Randomised scoreboard bench for alu_acc_ctrl with N=4, DEBOUNCE_CYCLES=4.
module tb_alu_acc_ctrl;

    localparam int unsigned N = 4;
    localparam int unsigned D = 4;
    localparam int unsigned LAT = 2 + 1 + D;

    typedef struct packed {
        logic [N-1:0] acc;
        logic         carry;
        logic [7:0]   count;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_n;
    logic         load;
    logic [N-1:0] operand;
    logic [N-1:0] result;
    logic         carry_out;
    logic [N-1:0] acc;
    logic         carry;
    logic         strobe;
    logic [7:0]   count;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;
    int   edge_cnt = 0;
    int   strobe_total = 0;
    int   last_strobe_edge = 0;

    // reference model state
    int m_acc = 0;
    int m_carry = 0;
    int m_count = 0;

    alu_acc_ctrl #(
        .N               (N),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_key_n     (key_n),
        .i_load      (load),
        .i_operand   (operand),
        .i_result    (result),
        .i_carry_out (carry_out),
        .o_acc       (acc),
        .o_carry     (carry),
        .o_strobe    (strobe),
        .o_count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic model_reset();
        m_acc = 0;
        m_carry = 0;
        m_count = 0;
    endtask

    task automatic expect_commit(input logic l, input logic [N-1:0] op,
                                 input logic [N-1:0] res, input logic co);
        exp_t e;
        if (l) begin
            m_acc = int'(op);
            m_carry = 0;
        end else begin
            m_acc = int'(res);
            m_carry = int'(co);
        end
        m_count = (m_count + 1) % 256;
        e.acc = m_acc[N-1:0];
        e.carry = m_carry[0];
        e.count = m_count[7:0];
        sb.push_back(e);
    endtask

    task automatic set_inputs(input logic l, input logic [N-1:0] op,
                              input logic [N-1:0] res, input logic co);
        load = l;
        operand = op;
        result = res;
        carry_out = co;
    endtask

    task automatic key_for(input logic lvl, input int n);
        key_n = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic clean_press(input logic l, input logic [N-1:0] op,
                               input logic [N-1:0] res, input logic co, input int low_len);
        set_inputs(l, op, res, co);
        expect_commit(l, op, res, co);
        key_for(1'b0, low_len);
        key_for(1'b1, 10);
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_acc"}, int'(acc), m_acc);
        chk({tag, "_carry"}, int'(carry), m_carry);
        chk({tag, "_count"}, int'(count), m_count);
    endtask

    // Monitor: every strobe must match the oldest pending expected commit.
    always @(posedge clk) begin
        edge_cnt++;
        #1;
        if (strobe) begin
            exp_t e;
            strobe_total++;
            last_strobe_edge = edge_cnt;
            if (sb.size() == 0) begin
                chk("unexpected_strobe", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("commit_acc", int'(acc), int'(e.acc));
                chk("commit_carry", int'(carry), int'(e.carry));
                chk("commit_count", int'(count), int'(e.count));
            end
        end
    end

    initial begin
        int s0;
        int key_edge;
        rst = 1'b1;
        key_n = 1'b1;
        set_inputs(1'b0, '0, '0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_outputs("reset");
        chk("reset_strobe", int'(strobe), 0);

        // Load operand and measure strobe latency
        s0 = strobe_total;
        set_inputs(1'b1, 4'h9, 4'h0, 1'b1);
        expect_commit(1'b1, 4'h9, 4'h0, 1'b1);
        key_edge = edge_cnt;
        key_for(1'b0, 12);
        key_for(1'b1, 10);
        chk("load_strobes", strobe_total - s0, 1);
        chk("load_latency", last_strobe_edge - key_edge, int'(LAT));
        check_outputs("load");

        // Capture ALU result and carry
        s0 = strobe_total;
        clean_press(1'b0, 4'($urandom), 4'h3, 1'b1, 12);
        chk("capture_strobes", strobe_total - s0, 1);
        check_outputs("capture");

        // Asynchronous reset mid-clock with nonzero outputs
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outputs("async_reset");
        chk("async_reset_strobe", int'(strobe), 0);
        @(negedge clk);
        rst = 1'b0;

        // Give the accumulator a nonzero value, then bounce
        clean_press(1'b1, 4'hA, 4'h0, 1'b0, 10);
        s0 = strobe_total;
        set_inputs(1'b1, 4'h5, 4'h6, 1'b1);
        key_for(1'b0, 2);
        key_for(1'b1, 1);
        key_for(1'b0, 2);
        key_for(1'b1, 10);
        chk("bounce_strobes", strobe_total - s0, 0);
        check_outputs("bounce");

        // Long hold with release bounce
        s0 = strobe_total;
        set_inputs(1'b0, 4'h1, 4'($urandom), 1'($urandom));
        expect_commit(load, operand, result, carry_out);
        key_for(1'b0, 100);
        key_for(1'b1, 1);
        key_for(1'b0, 1);
        key_for(1'b1, 10);
        chk("hold_strobes", strobe_total - s0, 1);
        check_outputs("hold");

        // Reset during PRESS_WAIT with counter at 2, key still held afterwards
        s0 = strobe_total;
        set_inputs(1'b1, 4'hC, 4'h2, 1'b1);
        key_for(1'b0, 5);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        chk("pw_reset_strobes", strobe_total - s0, 0);
        check_outputs("pw_reset");
        expect_commit(1'b1, 4'hC, 4'h2, 1'b1);
        rst = 1'b0;
        key_edge = edge_cnt;
        key_for(1'b0, 12);
        key_for(1'b1, 10);
        chk("held_after_reset_strobes", strobe_total - s0, 1);
        chk("held_after_reset_latency", last_strobe_edge - key_edge, int'(LAT));

        // 256 random presses from reset: count wraps back to 0
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        s0 = strobe_total;
        for (int i = 0; i < 256; i++) begin
            clean_press(1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom),
                        int'($urandom_range(8, 14)));
        end
        chk("wrap_strobes", strobe_total - s0, 256);
        chk("wrap_count", int'(count), 0);
        check_outputs("wrap");
        chk("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
